// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch-stage sequencer.
//   state_t : fetch_ctrl FSM encoding (RUN, MOVC_RD, MOVC_RST, HALT)
//   CNT_W   : width of the performance counters
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MOVC_RD  = 2'b01,
    MOVC_RST = 2'b10,
    HALT     = 2'b11
  } state_t;

  localparam int CNT_W = 16;

endpackage : fetch_pkg

// File: rtl/fetch_sat_cnt16.sv
// sat_cnt16: CNT_W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   inc        : add one this cycle (ignored once saturated)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module sat_cnt16
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : sat_cnt16

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer for the 5-stage 16-bit pipeline.
// Produces PC / IM_ID / ID_EX stall and flush controls, arbitrates the
// single-port instruction memory between fetch and LWI (movc) reads, and
// handles halt.
//   Inputs : clk, rst_n, flow_change_ID_EX, load_use_hz_ID, LWI_instr_ID_EX,
//            hlt_ID, perf_clr
//   Outputs: stall_IM_ID, stall_ID_EX, flush_IM_ID, flush_ID_EX,
//            imem_sel_movc, movc_data_vld, halted, movc_err (sticky),
//            stall_cnt, flush_cnt
// Build option: define FETCH_PERF_EN to enable the saturating stall/flush
// counters; otherwise they read as zero and perf_clr is unused.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flow_change_ID_EX,
  input  logic             load_use_hz_ID,
  input  logic             LWI_instr_ID_EX,
  input  logic             hlt_ID,
  input  logic             perf_clr,
  output logic             stall_IM_ID,
  output logic             stall_ID_EX,
  output logic             flush_IM_ID,
  output logic             flush_ID_EX,
  output logic             imem_sel_movc,
  output logic             movc_data_vld,
  output logic             halted,
  output logic             movc_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state, state_nxt;
  logic   stall_im, stall_ex, flush_im, flush_ex, sel_movc, data_vld, hlt_st;
  logic   err_set;

  // Controls are combinational so the PC and pipeline registers act on them
  // at the same edge the FSM advances.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    stall_im  = 1'b0;
    stall_ex  = 1'b0;
    flush_im  = 1'b0;
    flush_ex  = 1'b0;
    sel_movc  = 1'b0;
    data_vld  = 1'b0;
    hlt_st    = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      RUN: begin
        if (flow_change_ID_EX) begin
          // Everything behind a taken branch is wrong-path, including an LWI
          // arriving together with it, which is reported instead.
          flush_im = 1'b1;
          flush_ex = 1'b1;
          err_set  = LWI_instr_ID_EX;
        end else if (LWI_instr_ID_EX) begin
          stall_im  = 1'b1;
          stall_ex  = 1'b1;
          state_nxt = MOVC_RD;
        end else if (load_use_hz_ID) begin
          stall_im = 1'b1;
          flush_ex = 1'b1;
        end else if (hlt_ID) begin
          stall_im  = 1'b1;
          state_nxt = HALT;
        end
      end
      MOVC_RD: begin
        sel_movc  = 1'b1;
        stall_im  = 1'b1;
        stall_ex  = 1'b1;
        state_nxt = MOVC_RST;
      end
      MOVC_RST: begin
        // Memory address is back on the PC so the instruction displaced by
        // the data read is fetched again; ID_EX gets a bubble.
        data_vld  = 1'b1;
        stall_im  = 1'b1;
        flush_ex  = 1'b1;
        state_nxt = RUN;
      end
      HALT: begin
        stall_im = 1'b1;
        hlt_st   = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Gate with rst_n so nothing leaks out from live inputs while in reset.
  assign stall_IM_ID   = rst_n & stall_im;
  assign stall_ID_EX   = rst_n & stall_ex;
  assign flush_IM_ID   = rst_n & flush_im;
  assign flush_ID_EX   = rst_n & flush_ex;
  assign imem_sel_movc = rst_n & sel_movc;
  assign movc_data_vld = rst_n & data_vld;
  assign halted        = rst_n & hlt_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      movc_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) movc_err <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_IM_ID),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

  sat_cnt16 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_IM_ID | flush_ID_EX),
    .clr   (perf_clr),
    .cnt   (flush_cnt)
  );
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt       = '0;
  assign flush_cnt       = '0;
`endif

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A cycle table drives
// the main sequencing cases through a scoreboard queue; hand-written
// sequences cover reset while halted, reset mid-LWI and (with FETCH_PERF_EN)
// counter saturation and clear.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flow_change_ID_EX = 1'b0;
  logic             load_use_hz_ID = 1'b0;
  logic             LWI_instr_ID_EX = 1'b0;
  logic             hlt_ID = 1'b0;
  logic             perf_clr = 1'b0;
  logic             stall_IM_ID, stall_ID_EX, flush_IM_ID, flush_ID_EX;
  logic             imem_sel_movc, movc_data_vld, halted, movc_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flow_change_ID_EX (flow_change_ID_EX),
    .load_use_hz_ID    (load_use_hz_ID),
    .LWI_instr_ID_EX   (LWI_instr_ID_EX),
    .hlt_ID            (hlt_ID),
    .perf_clr          (perf_clr),
    .stall_IM_ID       (stall_IM_ID),
    .stall_ID_EX       (stall_ID_EX),
    .flush_IM_ID       (flush_IM_ID),
    .flush_ID_EX       (flush_ID_EX),
    .imem_sel_movc     (imem_sel_movc),
    .movc_data_vld     (movc_data_vld),
    .halted            (halted),
    .movc_err          (movc_err),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  always #5 clk = ~clk;

  // in  = {flow, load_use, lwi, hlt}
  // exp = {stall_IM_ID, stall_ID_EX, flush_IM_ID, flush_ID_EX,
  //        imem_sel_movc, movc_data_vld, halted, movc_err}
  typedef struct packed {
    logic [3:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[19];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_stall = 0;
  int         exp_flush = 0;

  function automatic logic [7:0] ctl_out();
    return {stall_IM_ID, stall_ID_EX, flush_IM_ID, flush_ID_EX,
            imem_sel_movc, movc_data_vld, halted, movc_err};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives one cycle, compares at the
  // falling edge, returns just after the next rising edge.
  task automatic step(input vec_t v, input string name);
    logic [7:0] e;
    {flow_change_ID_EX, load_use_hz_ID, LWI_instr_ID_EX, hlt_ID} = v.in;
    exp_q.push_back(v.exp);
    if (v.exp[7]) exp_stall++;
    if (v.exp[5] | v.exp[4]) exp_flush++;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {56'd0, ctl_out()}, {56'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {24'd0, ctl_out(), stall_cnt, flush_cnt}, 64'd0);
  endtask

  task automatic clear_inputs();
    {flow_change_ID_EX, load_use_hz_ID, LWI_instr_ID_EX, hlt_ID} = 4'b0000;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 8'b0000_0000}; // idle
    vecs[1]  = '{4'b1000, 8'b0011_0000}; // branch: flush both
    vecs[2]  = '{4'b0000, 8'b0000_0000};
    vecs[3]  = '{4'b0010, 8'b1100_0000}; // LWI cycle 1
    vecs[4]  = '{4'b1000, 8'b1100_1000}; // MOVC_RD, branch ignored
    vecs[5]  = '{4'b0001, 8'b1001_0100}; // MOVC_RST, halt ignored
    vecs[6]  = '{4'b0000, 8'b0000_0000};
    vecs[7]  = '{4'b0100, 8'b1001_0000}; // load-use bubble
    vecs[8]  = '{4'b1100, 8'b0011_0000}; // load-use + branch: flush only
    vecs[9]  = '{4'b0110, 8'b1100_0000}; // LWI beats load-use
    vecs[10] = '{4'b0000, 8'b1100_1000};
    vecs[11] = '{4'b0000, 8'b1001_0100};
    vecs[12] = '{4'b1010, 8'b0011_0000}; // LWI + branch: error
    vecs[13] = '{4'b0000, 8'b0000_0001}; // error now visible
    vecs[14] = '{4'b0101, 8'b1001_0001}; // load-use beats halt
    vecs[15] = '{4'b0001, 8'b1000_0001}; // halt decoded
    vecs[16] = '{4'b1000, 8'b1000_0011}; // halted, branch ignored
    vecs[17] = '{4'b0010, 8'b1000_0011}; // halted, LWI ignored
    vecs[18] = '{4'b0000, 8'b1000_0011};

    // Reset state
    #2;
    check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) step(vecs[i], $sformatf("vec%0d", i));

`ifdef FETCH_PERF_EN
    check("stall_cnt_table", {48'd0, stall_cnt}, 64'(exp_stall));
    check("flush_cnt_table", {48'd0, flush_cnt}, 64'(exp_flush));
    // Halted: stall every cycle, long enough to saturate.
    repeat (70000) @(posedge clk);
    #1;
    check("stall_cnt_sat", {48'd0, stall_cnt}, 64'hFFFF);
    check("flush_cnt_hold", {48'd0, flush_cnt}, 64'(exp_flush));
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("stall_cnt_clr", {48'd0, stall_cnt}, 64'd0);
    check("flush_cnt_clr", {48'd0, flush_cnt}, 64'd0);
    @(posedge clk);
    #1;
    check("stall_cnt_after_clr", {48'd0, stall_cnt}, 64'd1);
`else
    check("stall_cnt_tied", {48'd0, stall_cnt}, 64'd0);
    check("flush_cnt_tied", {48'd0, flush_cnt}, 64'd0);
`endif

    // Still halted many cycles later.
    repeat (5) @(posedge clk);
    #1;
    check("halt_persist", {56'd0, ctl_out()}, {56'd0, 8'b1000_0011});

    // Reset while halted with a branch pending: outputs drop at once.
    flow_change_ID_EX = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_halt");
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    step('{4'b0000, 8'b0000_0000}, "post_halt_idle");
    step('{4'b1000, 8'b0011_0000}, "post_halt_run");

    // Reset during MOVC_RD: sequence abandoned.
    step('{4'b0010, 8'b1100_0000}, "lwi_start");
    clear_inputs();
    #1;
    check("movc_rd_sel", {56'd0, ctl_out()}, {56'd0, 8'b1100_1000});
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_movc_rd");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      step('{4'b0000, 8'b0000_0000}, $sformatf("post_movc_idle%0d", i));
    step('{4'b0100, 8'b1001_0000}, "post_movc_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_ctrl
